// File: rtl/cache_axi_rd_arbiter.sv
// Read-channel arbiter that shares one AXI master port between the icache and
// the dcache. Only one transaction is in flight at a time. Simultaneous
// requests are resolved with a one-bit round-robin pointer. Read data from
// the slave is steered to the granted requester with no added latency.
module cache_axi_rd_arbiter (
  input  logic        clk,
  input  logic        rst,
  // icache read port
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  // dcache read port
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  // AXI master AR channel
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  // AXI master R channel
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  // status
  output logic        owner,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t      state;
  logic        ptr;        // 1 = dcache wins a tie, 0 = icache wins a tie
  logic [7:0]  beat_cnt;
  logic        grant_d;
  logic        ar_hs;
  logic        r_hs;
  logic        in_data;

  // Arbitration decision and handshake qualifiers
  always_comb begin
    grant_d  = d_arvalid && (!i_arvalid || ptr);
    in_data  = (state == DATA);
    ar_hs    = (state == ADDR) && m_arvalid && m_arready;
    m_rready = in_data && (owner ? d_rready : i_rready);
    r_hs     = m_rvalid && m_rready;
  end

  // Steer address acceptance and read data to the current owner only
  always_comb begin
    m_arsize  = 3'b010;
    m_arburst = 2'b01;
    i_arready = ar_hs && !owner;
    d_arready = ar_hs && owner;
    i_rdata   = m_rdata;
    d_rdata   = m_rdata;
    i_rvalid  = in_data && !owner && m_rvalid;
    i_rlast   = in_data && !owner && m_rlast;
    d_rvalid  = in_data && owner && m_rvalid;
    d_rlast   = in_data && owner && m_rlast;
  end

  // Transaction FSM with registered AR outputs, beat counter and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b1;
      owner     <= 1'b0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_arvalid || d_arvalid) begin
            owner     <= grant_d;
            m_araddr  <= grant_d ? d_araddr : i_araddr;
            m_arlen   <= grant_d ? d_arlen : i_arlen;
            m_arvalid <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            m_arvalid <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            // A last beat must land on beat arlen, and beat arlen must be last
            if (m_rlast != (beat_cnt == m_arlen)) begin
              err <= 1'b1;
            end
            if (m_rlast) begin
              ptr   <= !owner;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed bench for cache_axi_rd_arbiter: two requester agents, a simple
// AXI read slave, a transaction-level reference model checked every cycle,
// and literal expectations per scenario.
module tb_cache_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr, d_araddr, m_araddr, i_rdata, d_rdata, m_rdata;
  logic [7:0]  i_arlen, d_arlen, m_arlen;
  logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
  logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        owner, err;

  cache_axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  int cyc = 0;

  // requester agents: entries are {len, addr}
  logic [39:0] iq[$];
  logic [39:0] dq[$];
  int  i_pres = 0, d_pres = 0;
  bit  cfg_i_drop = 0;
  bit  cfg_i_rr_all = 1, cfg_d_rr_all = 1;
  int  glog[$];
  int  i_rx = 0, d_rx = 0;
  logic [31:0] i_last_data = '0;

  // slave agent
  int  cfg_ar_delay = 0;
  bit  cfg_short_en = 0;
  logic [7:0] cfg_short = 8'd0;
  bit  cfg_hold = 0, s_kill = 0;
  bit  s_active = 0;
  logic [7:0] s_beat = '0, s_last = '0;
  logic [31:0] s_addr = '0;
  int  ar_cnt = 0, arv_cycles = 0;

  // reference model
  bit  mbusy = 0, macc = 0, mown = 0, mptr = 1, merr = 0;
  logic [31:0] maddr = '0;
  logic [7:0]  mlen = '0, mbeats = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Drive requesters, cache rready and the slave on the falling edge
  always @(negedge clk) begin
    i_arvalid = (iq.size() > 0) && !(cfg_i_drop && i_pres > 0);
    i_araddr  = (iq.size() > 0) ? iq[0][31:0] : '0;
    i_arlen   = (iq.size() > 0) ? iq[0][39:32] : '0;
    d_arvalid = (dq.size() > 0);
    d_araddr  = (dq.size() > 0) ? dq[0][31:0] : '0;
    d_arlen   = (dq.size() > 0) ? dq[0][39:32] : '0;
    i_rready  = cfg_i_rr_all || (cyc % 3 != 0);
    d_rready  = cfg_d_rr_all || (cyc % 2 == 0);
    m_arready = m_arvalid && (ar_cnt >= cfg_ar_delay);
    m_rvalid  = s_active;
    m_rdata   = s_active ? (s_addr + 32'(s_beat) * 32'd4) : '0;
    m_rlast   = s_active && (s_beat == s_last);
  end

  // Agent bookkeeping on the rising edge
  always @(posedge clk) begin
    if (i_arready) begin void'(iq.pop_front()); i_pres = 0; glog.push_back(0); end
    else if (i_arvalid) i_pres++;
    if (d_arready) begin void'(dq.pop_front()); d_pres = 0; glog.push_back(1); end
    else if (d_arvalid) d_pres++;
    if (i_rvalid && i_rready && !rst) begin i_rx++; i_last_data = i_rdata; end
    if (d_rvalid && d_rready && !rst) d_rx++;
    if (s_kill || (rst && !cfg_hold)) begin
      s_active = 0;
      ar_cnt = 0;
    end else begin
      if (s_active && m_rvalid && m_rready) begin
        if (m_rlast) s_active = 0;
        else s_beat++;
      end
      if (m_arvalid && m_arready) begin
        s_active = 1; s_beat = '0; s_addr = m_araddr;
        s_last = cfg_short_en ? cfg_short : m_arlen;
        ar_cnt = 0; arv_cycles++;
      end else if (m_arvalid) begin
        ar_cnt++; arv_cycles++;
      end
    end
  end

  // Reference model: one transaction at a time, round-robin tie break
  always @(posedge clk) begin
    if (rst) begin
      mbusy = 0; macc = 0; mown = 0; mptr = 1; merr = 0;
      maddr = '0; mlen = '0; mbeats = '0;
    end else if (!mbusy) begin
      if (i_arvalid || d_arvalid) begin
        mown  = (i_arvalid && d_arvalid) ? mptr : d_arvalid;
        maddr = mown ? d_araddr : i_araddr;
        mlen  = mown ? d_arlen : i_arlen;
        mbusy = 1; macc = 0;
      end
    end else if (!macc) begin
      if (m_arready) begin macc = 1; mbeats = '0; end
    end else if (m_rvalid && (mown ? d_rready : i_rready)) begin
      if (m_rlast != (mbeats == mlen)) merr = 1;
      mbeats = mbeats + 8'd1;
      if (m_rlast) begin mbusy = 0; mptr = !mown; end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit dph;
    #2;
    if (chk_en) begin
      dph = mbusy && macc;
      chk("m_arvalid", m_arvalid, mbusy && !macc);
      chk("m_araddr", m_araddr, maddr);
      chk("m_arlen", m_arlen, mlen);
      chk("m_arsize", m_arsize, 3'b010);
      chk("m_arburst", m_arburst, 2'b01);
      chk("i_arready", i_arready, mbusy && !macc && m_arready && !mown);
      chk("d_arready", d_arready, mbusy && !macc && m_arready && mown);
      chk("m_rready", m_rready, dph && (mown ? d_rready : i_rready));
      chk("i_rvalid", i_rvalid, dph && !mown && m_rvalid);
      chk("i_rlast", i_rlast, dph && !mown && m_rlast);
      chk("d_rvalid", d_rvalid, dph && mown && m_rvalid);
      chk("d_rlast", d_rlast, dph && mown && m_rlast);
      if (dph && !mown && m_rvalid) chk("i_rdata", i_rdata, m_rdata);
      if (dph && mown && m_rvalid) chk("d_rdata", d_rdata, m_rdata);
      chk("owner", owner, mown);
      chk("err", err, merr);
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while ((iq.size() > 0 || dq.size() > 0 || mbusy || s_active) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < 400, 1'b1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp4[5] = '{1, 0, 1, 0, 1};
    int n;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    rst = 0;
    #3;
    chk("rst_owner", owner, 0);
    chk("rst_err", err, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_rready", m_rready, 0);

    // Lone icache burst of 8 beats
    i_rx = 0;
    @(posedge clk); #1 iq.push_back({8'd7, 32'h1FC0_0000});
    @(negedge clk); #3 chk("t1_arvalid_early", m_arvalid, 0);
    @(negedge clk); #3;
    chk("t1_arvalid_lat", m_arvalid, 1);
    chk("t1_araddr", m_araddr, 32'h1FC0_0000);
    chk("t1_arlen", m_arlen, 8'd7);
    chk("t1_arready", i_arready, 1);
    wait_idle("t1_done");
    chk("t1_beats", i_rx, 8);
    chk("t1_lastword", i_last_data, 32'h1FC0_001C);
    chk("t1_err", err, 0);

    // Simultaneous requests after reset: dcache first
    do_reset();
    glog.delete();
    cfg_i_rr_all = 0; cfg_d_rr_all = 0;
    @(posedge clk); #1;
    dq.push_back({8'd3, 32'h8000_0000});
    iq.push_back({8'd1, 32'h0000_1000});
    wait_idle("t2_done");
    chk("t2_count", glog.size(), 2);
    chk("t2_first", glog.size() > 0 ? glog[0] : 9, 1);
    chk("t2_second", glog.size() > 1 ? glog[1] : 9, 0);

    // Continuous dcache demand alternates with a waiting icache
    glog.delete();
    @(posedge clk); #1;
    dq.push_back({8'd1, 32'h8000_0100});
    dq.push_back({8'd1, 32'h8000_0200});
    dq.push_back({8'd1, 32'h8000_0300});
    iq.push_back({8'd2, 32'h0000_2000});
    iq.push_back({8'd2, 32'h0000_3000});
    wait_idle("t3_done");
    chk("t3_count", glog.size(), 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t3_order%0d", k), glog.size() > k ? glog[k] : 9, exp4[k]);

    // Slave stalls the address for 5 cycles
    cfg_ar_delay = 5; arv_cycles = 0; cfg_d_rr_all = 1;
    @(posedge clk); #1 dq.push_back({8'd0, 32'h0000_4000});
    wait_idle("t4_done");
    chk("t4_arv_cycles", arv_cycles, 6);

    // Early rlast on beat 4 of a len-7 burst, then error stays set
    cfg_ar_delay = 0; cfg_short_en = 1; cfg_short = 8'd3; i_rx = 0; cfg_i_rr_all = 1;
    @(posedge clk); #1 iq.push_back({8'd7, 32'h0000_5000});
    wait_idle("t5_done");
    cfg_short_en = 0;
    chk("t5_err", err, 1);
    chk("t5_beats", i_rx, 4);
    @(posedge clk); #1 dq.push_back({8'd1, 32'h0000_6000});
    wait_idle("t5b_done");
    chk("t5_err_sticky", err, 1);

    // Requester withdraws its request after being granted
    cfg_i_drop = 1; cfg_ar_delay = 2; i_rx = 0;
    @(posedge clk); #1 iq.push_back({8'd3, 32'h0000_9000});
    wait_idle("t6_done");
    chk("t6_beats", i_rx, 4);
    cfg_i_drop = 0; cfg_ar_delay = 0;

    // Reset on the third beat of an 8-beat dcache burst
    do_reset();
    #3 chk("t7_err_cleared", err, 0);
    cfg_hold = 1; d_rx = 0;
    @(posedge clk); #1 dq.push_back({8'd7, 32'h0000_7000});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_active && s_beat == 8'd2) && n < 100);
    chk("t7_reach_beat3", n < 100, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #3;
    chk("t7_slave_still_valid", m_rvalid, 1);
    chk("t7_d_rvalid", d_rvalid, 0);
    chk("t7_m_rready", m_rready, 0);
    chk("t7_owner", owner, 0);
    chk("t7_araddr", m_araddr, 0);
    repeat (3) @(negedge clk);
    s_kill = 1;
    @(posedge clk); #1 s_kill = 0; cfg_hold = 0;
    chk("t7_beats", d_rx, 2);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_axi_rd_arbiter.md
CACHE_AXI_RD_ARBITER -- requirements
Module: cache_axi_rd_arbiter

Interface
REQ-001 SHALL have no parameters; ARSIZE fixed 3'b010 (4 bytes), ARBURST fixed 2'b01 (INCR).
REQ-002 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 i_araddr / i_arlen / i_arvalid  in  32/8/1  icache read-address request.
REQ-006 i_arready  out  1  icache address accepted.
REQ-007 i_rdata / i_rlast / i_rvalid  out  32/1/1  icache read-data return.
REQ-008 i_rready  in  1  icache data acceptance.
REQ-009 d_araddr / d_arlen / d_arvalid / d_arready / d_rdata / d_rlast / d_rvalid / d_rready  SHALL mirror REQ-005..008 for the dcache read port.
REQ-010 m_araddr / m_arlen / m_arsize / m_arburst / m_arvalid  out  32/8/3/2/1  AXI master AR channel.
REQ-011 m_arready  in  1  AXI slave address ready.
REQ-012 m_rdata / m_rlast / m_rvalid  in  32/1/1  AXI R channel.
REQ-013 m_rready  out  1  AXI R ready.
REQ-014 owner  out  1  current grant (0 = icache, 1 = dcache), valid outside IDLE.
REQ-015 err  out  1  sticky burst-length protocol error.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA; one outstanding transaction only.
REQ-017 IDLE: if i_arvalid or d_arvalid, choose winner, register its araddr/arlen and owner, go to ADDR next cycle; else stay.
REQ-018 Arbitration SHALL be round-robin via 1-bit pointer: on simultaneous requests the requester indicated by the pointer wins; a lone requester always wins.
REQ-019 Pointer SHALL move to favour the non-owner when a transaction completes (rlast handshake).
REQ-020 ADDR: m_arvalid=1 carrying registered address/length; on m_arvalid&&m_arready assert owner's *_arready combinationally that same cycle and go to DATA.
REQ-021 m_araddr/m_arlen SHALL stay stable while m_arvalid=1 and m_arready=0.
REQ-022 DATA: m_rdata/m_rlast/m_rvalid routed to owner; m_rready = owner's *_rready; non-owner *_rvalid=0, *_rlast=0.
REQ-023 Non-owner *_arready SHALL be 0 in all states; both *_arready 0 in IDLE and DATA.
REQ-024 8-bit beat counter SHALL clear entering DATA and increment per m_rvalid&&m_rready beat.
REQ-025 Handshake with m_rlast=1 SHALL return FSM to IDLE next cycle; earliest next m_arvalid is 2 cycles after the rlast beat.
REQ-026 err SHALL set when m_rlast arrives with counter != registered arlen, or a non-last beat arrives with counter == arlen; FSM still terminates only on rlast.
REQ-027 m_rvalid in IDLE or ADDR SHALL be ignored (m_rready=0, nothing forwarded).
REQ-028 Requester deasserting *_arvalid after grant in IDLE SHALL NOT abort the transaction.
REQ-029 m_rdata SHALL pass with zero added latency; m_arvalid asserts 1 cycle after request seen in IDLE.

Reset
REQ-030 On rst: state IDLE, pointer favours dcache, owner=0, counter=0, err=0, m_arvalid=0, m_rready=0, all *_arready/*_rvalid/*_rlast=0, m_araddr=0, m_arlen=0.
REQ-031 rst SHALL take effect mid-transaction in any state, abandoning the burst with no further forwarding.

Verification
REQ-032 Lone icache req addr 0x1FC0_0000 len 7, m_arready=1 -> m_arvalid cycle+1, i_arready pulse, 8 beats to icache, IDLE after beat 8, err=0.
REQ-033 Simultaneous i/d requests after reset -> dcache served first (owner=1), then icache without re-request gap beyond REQ-025.
REQ-034 dcache requests continuously while icache waits -> grants alternate d,i,d,i.
REQ-035 m_arready held 0 for 5 cycles -> m_araddr/m_arlen stable, no *_arready until acceptance.
REQ-036 len 7 burst with m_rlast on beat 4 -> err=1 sticky, FSM returns IDLE.
REQ-037 rst asserted on beat 3 of 8 -> all outputs reset values next cycle, later beats not forwarded.
